// File: rtl/cheat_pgm_loader.sv
// Byte-wise command frame assembler for the cheat engine programming port.
// Collects SLOT/MASK/FLAGS/LOADALL payloads into 32-bit words and strobes them out when the port is not blocked.
module cheat_pgm_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        frame_start,
  input  logic        pgm_block,
  input  logic        err_clr,
  output logic        byte_ready,
  output logic        busy,
  output logic [2:0]  pgm_idx,
  output logic        pgm_we,
  output logic [31:0] pgm_in,
  output logic        err_badop,
  output logic        err_overrun,
  output logic        err_abort,
  output logic [7:0]  wr_count
);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_ISSUE, S_DISCARD} state_t;
  typedef enum logic [1:0] {OP_SLOT, OP_MASK, OP_FLAGS, OP_LOADALL} op_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [2:0]  sel_q, sel_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  word_q, word_d;
  logic [23:0] asm_q, asm_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] out_q, out_d;
  logic        badop_q, badop_d;
  logic        overrun_q, overrun_d;
  logic        abort_q, abort_d;
  logic [7:0]  wr_q, wr_d;

  op_t         hdr_op;
  logic        hdr_ok;
  logic [1:0]  last_cnt;
  logic        start;
  logic        set_badop, set_overrun, set_abort;

  always_comb begin
    hdr_op = OP_SLOT;
    hdr_ok = 1'b0;
    case (byte_in[7:4])
      4'h1: begin
        hdr_op = OP_SLOT;
        hdr_ok = (byte_in[2:0] <= 3'd5);
      end
      4'h2: begin
        hdr_op = OP_MASK;
        hdr_ok = 1'b1;
      end
      4'h3: begin
        hdr_op = OP_FLAGS;
        hdr_ok = 1'b1;
      end
      4'h4: begin
        hdr_op = OP_LOADALL;
        hdr_ok = 1'b1;
      end
      default: hdr_ok = 1'b0;
    endcase
  end

  // Index of the byte that completes the current word.
  always_comb begin
    last_cnt = 2'd3;
    case (op_q)
      OP_SLOT:    last_cnt = 2'd3;
      OP_MASK:    last_cnt = 2'd0;
      OP_FLAGS:   last_cnt = 2'd1;
      OP_LOADALL: last_cnt = (word_q == 3'd6) ? 2'd0 : 2'd3;
      default:    last_cnt = 2'd3;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    asm_d       = asm_q;
    idx_d       = idx_q;
    out_d       = out_q;
    wr_d        = wr_q;
    pgm_we      = 1'b0;
    start       = 1'b0;
    set_badop   = 1'b0;
    set_overrun = 1'b0;
    set_abort   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (byte_valid && frame_start) start = 1'b1;
      end
      S_PAYLOAD: begin
        if (byte_valid) begin
          if (frame_start) begin
            set_abort = 1'b1;
            start     = 1'b1;
          end else begin
            asm_d = {asm_q[15:0], byte_in};
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == last_cnt) begin
              cnt_d   = 2'd0;
              state_d = S_ISSUE;
              case (op_q)
                OP_SLOT: begin
                  idx_d = sel_q;
                  out_d = {asm_q, byte_in};
                end
                OP_MASK: begin
                  idx_d = 3'd6;
                  out_d = {26'b0, byte_in[5:0]};
                end
                OP_FLAGS: begin
                  // First payload byte is the set mask, second the clear mask.
                  idx_d = 3'd7;
                  out_d = {18'b0, byte_in[5:0], 2'b00, asm_q[5:0]};
                end
                OP_LOADALL: begin
                  idx_d = word_q;
                  out_d = (word_q == 3'd6) ? {26'b0, byte_in[5:0]} : {asm_q, byte_in};
                end
                default: begin
                  idx_d = idx_q;
                  out_d = out_q;
                end
              endcase
            end
          end
        end
      end
      S_ISSUE: begin
        if (byte_valid) set_overrun = 1'b1;
        if (!pgm_block) begin
          pgm_we = 1'b1;
          wr_d   = wr_q + 8'd1;
          if (op_q == OP_LOADALL && word_q != 3'd6) begin
            word_d  = word_q + 3'd1;
            state_d = S_PAYLOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DISCARD: begin
        if (byte_valid && frame_start) begin
          set_abort = 1'b1;
          start     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      op_d   = hdr_op;
      sel_d  = byte_in[2:0];
      cnt_d  = 2'd0;
      word_d = 3'd0;
      if (hdr_ok) begin
        state_d = S_PAYLOAD;
      end else begin
        state_d   = S_DISCARD;
        set_badop = 1'b1;
      end
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  assign badop_d   = set_badop   | (badop_q   & ~err_clr);
  assign overrun_d = set_overrun | (overrun_q & ~err_clr);
  assign abort_d   = set_abort   | (abort_q   & ~err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_SLOT;
      sel_q     <= 3'd0;
      cnt_q     <= 2'd0;
      word_q    <= 3'd0;
      asm_q     <= 24'd0;
      idx_q     <= 3'd0;
      out_q     <= 32'd0;
      badop_q   <= 1'b0;
      overrun_q <= 1'b0;
      abort_q   <= 1'b0;
      wr_q      <= 8'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      asm_q     <= asm_d;
      idx_q     <= idx_d;
      out_q     <= out_d;
      badop_q   <= badop_d;
      overrun_q <= overrun_d;
      abort_q   <= abort_d;
      wr_q      <= wr_d;
    end
  end

  assign byte_ready  = (state_q != S_ISSUE);
  assign busy        = (state_q != S_IDLE);
  assign pgm_idx     = idx_q;
  assign pgm_in      = out_q;
  assign err_badop   = badop_q;
  assign err_overrun = overrun_q;
  assign err_abort   = abort_q;
  assign wr_count    = wr_q;

endmodule

// File: doc/cheat_pgm_loader.md
# cheat_pgm_loader

MCU-side writer for the cheat/hook programming port. It takes command frames delivered byte-wise by the MCU command path. It assembles them into 32-bit programming words and issues them on the `pgm_idx` / `pgm_we` / `pgm_in` port of the cheat engine. Any write that would collide with an SNES-side cycle that the cheat engine services first is held back until the port is free.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous assert, active low.
- `byte_in`  in  8  frame byte from the MCU command path.
- `byte_valid`  in  1  one-cycle strobe; `byte_in` is valid.
- `frame_start`  in  1  asserted together with `byte_valid` on the header byte of a frame.
- `pgm_block`  in  1  high means the cheat engine ignores `pgm_we` this cycle. Driven as (snescmd unlock & snescmd write strobe) | SNES reset strobe.
- `byte_ready`  out  1  high when a byte can be accepted.
- `busy`  out  1  a frame is in progress or a write is pending.
- `pgm_idx`  out  3  programming slot index.
- `pgm_we`  out  1  one-cycle write strobe.
- `pgm_in`  out  32  programming word.
- `err_badop`  out  1  sticky: unknown opcode, or slot index > 5.
- `err_overrun`  out  1  sticky: `byte_valid` arrived while `byte_ready` was low.
- `err_abort`  out  1  sticky: `frame_start` arrived mid-frame.
- `err_clr`  in  1  clears all three sticky errors.
- `wr_count`  out  8  count of issued writes, wraps at 255→0.

## Operation
- **Header byte.** `op` = `byte_in[7:4]`, `sel` = `byte_in[2:0]`.
- **Ops:**
  - 0x1 SLOT: payload is 4 bytes b0..b3, MSB first. Issues `pgm_idx`=`sel`, `pgm_in`={b0,b1,b2,b3}, i.e. addr[23:0]={b0,b1,b2}, data=b3. Valid only for `sel` ≤ 5.
  - 0x2 MASK: payload is 1 byte m. Issues idx 6, `pgm_in`={26'b0, m[5:0]}.
  - 0x3 FLAGS: payload is 2 bytes, set s then clear c. Issues idx 7, `pgm_in`={18'b0, c[5:0], 2'b00, s[5:0]}.
  - 0x4 LOADALL: payload is 25 bytes. Slots 0..5 take 4 bytes each, then 1 mask byte. Issues 7 writes in order: idx 0,1,2,3,4,5,6.
  - Any other op, or SLOT with `sel` > 5: set `err_badop` and go to DISCARD.
- **States:**
  - IDLE: a header arriving with `frame_start` → PAYLOAD (or DISCARD for a bad op). `byte_valid` without `frame_start` → ignored.
  - PAYLOAD: each accepted byte shifts into the assembly register; the byte counter increments. A word completes on the 4th byte (SLOT, LOADALL slot words), 1st byte (MASK, LOADALL last byte) or 2nd byte (FLAGS). On completion: load the issue register → ISSUE.
  - ISSUE: `byte_ready`=0. On the first cycle with `pgm_block`=0: `pgm_we`=1 for exactly that cycle, `wr_count`+1. Next state: PAYLOAD if LOADALL words remain, else IDLE.
  - DISCARD: accept and drop bytes until the next `frame_start`.
- **Abort.** `frame_start` in PAYLOAD or DISCARD sets `err_abort` and drops the partial word. That header is then processed as a new frame. LOADALL words already issued stay written.
- **Simultaneous events.**
  - `err_clr` together with a new error in the same cycle: the error wins (flag stays set).
  - `byte_valid` while in ISSUE: the byte is dropped and `err_overrun` is set. No state change.
- `busy` = state ≠ IDLE.

## Timing
- **Reset values.** `rst_n` low, at any time including mid-frame or with a write pending, forces:
  - state IDLE, `byte_ready`=1, `busy`=0, `pgm_we`=0;
  - `pgm_idx`=0, `pgm_in`=0;
  - all error flags 0, `wr_count`=0.
  - Pending writes are lost.
- `byte_ready` is 1 in IDLE, PAYLOAD and DISCARD, and 0 in ISSUE.
- **Latency.** If the final byte is accepted in cycle N with `pgm_block`=0 at N+1, `pgm_we`=1 in cycle N+1. A blocked cycle delays the strobe by one cycle per blocked cycle, with no upper bound.
- `pgm_idx` and `pgm_in` are registered. They are valid from cycle N+1 and held until the next word is loaded, so they are stable on the strobe cycle.
- `pgm_we` is never high on a cycle where `pgm_block`=1.
- `wr_count` updates on the cycle after the strobe.
- Error flags set on the cycle after the triggering byte.
- LOADALL back-to-back minimum: 4 byte cycles + 1 issue cycle per slot word.

## Test plan
- **SLOT write.** Header 0x13, payload 7E 12 34 A9, `pgm_block`=0 → one `pgm_we` with idx 3, `pgm_in`=0x7E1234A9, arriving 1 cycle after the last byte; `wr_count`=1.
- **FLAGS with blocking.** Header 0x30, payload 05 02; hold `pgm_block`=1 for 3 cycles → `pgm_we` on the 4th cycle with idx 7, `pgm_in`=0x00000205; `byte_ready`=0 throughout; no strobe while blocked.
- **LOADALL.** Header 0x40 plus 25 bytes (slot k = k1 k2 k3 k4, then mask 0x3F) → 7 strobes with idx 0..6 in order; the last has `pgm_in`=0x0000003F; `wr_count`=7; `busy` falls after the 7th strobe.
- **Bad op / bad slot.** Header 0x16 or 0x70 plus 4 bytes → `err_badop`=1, no `pgm_we`. A following valid MASK frame (0x20, 0x15) issues idx 6 with `pgm_in`=0x15.
- **Abort and overrun.**
  - `frame_start` after 2 SLOT bytes → `err_abort`=1, no write, and the new header is decoded.
  - `byte_valid` during ISSUE → `err_overrun`=1, the byte is dropped, and the pending write still completes.
  - `err_clr` clears all error flags.
- **Reset mid-frame.** Pulse `rst_n` low during ISSUE with `pgm_block`=1 → `pgm_we` never asserts; all outputs are at reset values; a subsequent frame works normally.
